// File: rtl/mips_run_ctrl.sv
// -----------------------------------------------------------------------------
// mips_run_ctrl
//
// Run controller that sits between the clock source and a mips core and
// replaces hand-timed reset sequencing in the bench.
//   - Holds the core in reset for RST_HOLD cycles after a start request.
//   - Optionally issues one mid-run re-reset when the run has lasted REARM_AT
//     cycles. The re-reset lasts REARM_LEN cycles.
//   - Counts run cycles (RUN + REARM) and retired instructions.
//   - Flags program end when STALL_LIMIT consecutive retires land on one PC.
//   - Flags a watchdog timeout when the run reaches TIMEOUT cycles.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-low; clears all state
//   start      in   1      launches a run from IDLE, DONE or TOUT
//   pc         in   PC_W   PC of the retiring instruction
//   pc_valid   in   1      one instruction retires this cycle
//   cpu_reset  out  1      active-high reset to the core (low only in RUN)
//   running    out  1      high only in RUN
//   done       out  1      sticky program-end flag
//   timeout    out  1      sticky watchdog flag
//   cycles     out  CNT_W  cycles spent in RUN + REARM since start
//   retired    out  CNT_W  retires since start or since the last re-reset
//   state      out  3      IDLE=0 HOLD=1 RUN=2 REARM=3 DONE=4 TOUT=5
//
// All outputs are registered. A state change decided at one edge is visible
// on the outputs after that edge.
// -----------------------------------------------------------------------------
module mips_run_ctrl #(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int RST_HOLD    = 4,
  parameter int STALL_LIMIT = 8,
  parameter int TIMEOUT     = 100000,
  parameter int REARM_AT    = 0,
  parameter int REARM_LEN   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_REARM = 3'd3,
    ST_DONE  = 3'd4,
    ST_TOUT  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO       = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
  // Every "last" value is compared against the counter's current value, so the
  // transition fires on the edge that completes the final counted cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST      = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] REARM_LEN_LAST = CNT_W'(REARM_LEN - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] REARM_LAST     = CNT_W'((REARM_AT > 0) ? (REARM_AT - 1) : 0);
  // stall_cnt counts repeats after the first retire at a PC, so the
  // STALL_LIMIT-th retire is the one that finds stall_cnt at STALL_LIMIT-2.
  localparam logic [CNT_W-1:0] STALL_LAST     = CNT_W'(STALL_LIMIT - 2);
  localparam logic             REARM_EN       = (REARM_AT != 0) ? 1'b1 : 1'b0;

  state_e            state_q, state_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  // Shared by HOLD and REARM: cycles already spent in the current reset phase.
  logic [CNT_W-1:0]  phase_cnt_q, phase_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [PC_W-1:0]   last_pc_q, last_pc_d;
  // Set while no instruction has retired since start or since the re-reset;
  // the next retire then loads last_pc unconditionally.
  logic              first_q, first_d;
  logic              rearmed_q, rearmed_d;

  logic              hit_stall;
  logic              hit_tout;
  logic              hit_rearm;

  // Next-state and next-output computation for the run sequencer.
  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    cycles_d    = cycles_q;
    retired_d   = retired_q;
    phase_cnt_d = phase_cnt_q;
    stall_cnt_d = stall_cnt_q;
    last_pc_d   = last_pc_q;
    first_d     = first_q;
    rearmed_d   = rearmed_q;
    hit_stall   = 1'b0;
    hit_tout    = 1'b0;
    hit_rearm   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_TOUT: begin
        if (start) begin
          state_d     = ST_HOLD;
          done_d      = 1'b0;
          timeout_d   = 1'b0;
          cycles_d    = CNT_ZERO;
          retired_d   = CNT_ZERO;
          phase_cnt_d = CNT_ZERO;
          stall_cnt_d = CNT_ZERO;
          first_d     = 1'b1;
          rearmed_d   = 1'b0;
        end else begin
          state_d     = state_q;
        end
      end

      ST_HOLD: begin
        if (phase_cnt_q == HOLD_LAST) begin
          state_d     = ST_RUN;
          phase_cnt_d = CNT_ZERO;
        end else begin
          phase_cnt_d = phase_cnt_q + CNT_ONE;
        end
      end

      ST_RUN: begin
        cycles_d  = cycles_q + CNT_ONE;
        hit_tout  = (cycles_q == TIMEOUT_LAST);
        hit_rearm = REARM_EN && !rearmed_q && (cycles_q == REARM_LAST);

        if (pc_valid) begin
          retired_d = retired_q + CNT_ONE;
          if (!first_q && (pc == last_pc_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
            hit_stall   = (stall_cnt_q == STALL_LAST);
          end else begin
            stall_cnt_d = CNT_ZERO;
            last_pc_d   = pc;
            first_d     = 1'b0;
          end
        end else begin
          retired_d = retired_q;
        end

        // Program end beats the watchdog, and both beat the re-reset.
        if (hit_stall) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (hit_tout) begin
          state_d   = ST_TOUT;
          timeout_d = 1'b1;
        end else if (hit_rearm) begin
          state_d     = ST_REARM;
          rearmed_d   = 1'b1;
          phase_cnt_d = CNT_ZERO;
          retired_d   = CNT_ZERO;
          stall_cnt_d = CNT_ZERO;
          first_d     = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_REARM: begin
        // The run clock keeps going through the re-reset, so the watchdog
        // stays armed; retirement history restarts from scratch.
        cycles_d    = cycles_q + CNT_ONE;
        retired_d   = CNT_ZERO;
        stall_cnt_d = CNT_ZERO;
        first_d     = 1'b1;
        if (cycles_q == TIMEOUT_LAST) begin
          state_d     = ST_TOUT;
          timeout_d   = 1'b1;
          phase_cnt_d = CNT_ZERO;
        end else if (phase_cnt_q == REARM_LEN_LAST) begin
          state_d     = ST_RUN;
          phase_cnt_d = CNT_ZERO;
        end else begin
          phase_cnt_d = phase_cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cpu_reset_d = (state_d != ST_RUN);
    running_d   = (state_d == ST_RUN);
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cycles_q    <= CNT_ZERO;
      retired_q   <= CNT_ZERO;
      phase_cnt_q <= CNT_ZERO;
      stall_cnt_q <= CNT_ZERO;
      last_pc_q   <= {PC_W{1'b0}};
      first_q     <= 1'b1;
      rearmed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_reset_q <= cpu_reset_d;
      running_q   <= running_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      cycles_q    <= cycles_d;
      retired_q   <= retired_d;
      phase_cnt_q <= phase_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      last_pc_q   <= last_pc_d;
      first_q     <= first_d;
      rearmed_q   <= rearmed_d;
    end
  end

  assign cpu_reset = cpu_reset_q;
  assign running   = running_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cycles    = cycles_q;
  assign retired   = retired_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_run_ctrl
// Three controllers with different parameter sets share one stimulus stream.
// The driver advances a per-instance reference model at every clock and queues
// the expected registered outputs; a monitor pops and compares on the falling
// edge. Directed phases are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_mips_run_ctrl;

  localparam int RH    = 4;
  localparam int SL    = 8;
  localparam int RL    = 15;
  localparam int TO_0  = 100000;
  localparam int TO_1  = 50;
  localparam int TO_2  = 120;
  localparam int RA_2  = 20;

  localparam int PH_IDLE  = 0;
  localparam int PH_HOLD  = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_REARM = 3;
  localparam int PH_DONE  = 4;
  localparam int PH_TOUT  = 5;

  typedef struct {
    int rst_hold;
    int stall_limit;
    int timeout;
    int rearm_at;
    int rearm_len;
  } prm_t;

  typedef struct {
    int          phase;
    bit          done;
    bit          tout;
    int          cycles;
    int          retired;
    int          hold_left;
    int          rearm_left;
    int          run_len;    // consecutive retires at last_pc, 0 = none yet
    logic [31:0] last_pc;
    bit          rearmed;
  } mdl_t;

  typedef struct packed {
    logic [2:0]  st;
    logic        cr;
    logic        rn;
    logic        dn;
    logic        to;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  typedef struct {
    exp_t e [3];
  } trio_t;

  logic        clk = 1'b0;
  logic        reset, start, pc_valid;
  logic [31:0] pc;

  logic [2:0]  cr_o, rn_o, dn_o, to_o;
  logic [2:0]  st0, st1, st2;
  logic [31:0] cyc0, cyc1, cyc2, ret0, ret1, ret2;

  int    checks = 0;
  int    errors = 0;
  trio_t sbq [$];
  mdl_t  m [3];
  prm_t  pr [3];

  always #5 clk = ~clk;

  mips_run_ctrl #(.PC_W(32), .CNT_W(32), .RST_HOLD(RH), .STALL_LIMIT(SL),
                  .TIMEOUT(TO_0), .REARM_AT(0), .REARM_LEN(RL)) u0 (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .pc_valid(pc_valid),
    .cpu_reset(cr_o[0]), .running(rn_o[0]), .done(dn_o[0]), .timeout(to_o[0]),
    .cycles(cyc0), .retired(ret0), .state(st0));

  mips_run_ctrl #(.PC_W(32), .CNT_W(32), .RST_HOLD(RH), .STALL_LIMIT(SL),
                  .TIMEOUT(TO_1), .REARM_AT(0), .REARM_LEN(RL)) u1 (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .pc_valid(pc_valid),
    .cpu_reset(cr_o[1]), .running(rn_o[1]), .done(dn_o[1]), .timeout(to_o[1]),
    .cycles(cyc1), .retired(ret1), .state(st1));

  mips_run_ctrl #(.PC_W(32), .CNT_W(32), .RST_HOLD(RH), .STALL_LIMIT(SL),
                  .TIMEOUT(TO_2), .REARM_AT(RA_2), .REARM_LEN(RL)) u2 (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .pc_valid(pc_valid),
    .cpu_reset(cr_o[2]), .running(rn_o[2]), .done(dn_o[2]), .timeout(to_o[2]),
    .cycles(cyc2), .retired(ret2), .state(st2));

  // Reference model: one clock of the controller's rules.
  function automatic mdl_t step(input mdl_t m0, input prm_t p, input logic rst_n,
                                input logic s, input logic v, input logic [31:0] pcx);
    mdl_t m;
    bit   end_hit, to_hit, re_hit;
    m = m0;
    end_hit = 1'b0;
    if (!rst_n) begin
      m.phase = PH_IDLE; m.done = 1'b0; m.tout = 1'b0; m.cycles = 0; m.retired = 0;
      m.hold_left = 0; m.rearm_left = 0; m.run_len = 0; m.last_pc = 32'd0; m.rearmed = 1'b0;
      return m;
    end
    case (m.phase)
      PH_IDLE, PH_DONE, PH_TOUT: begin
        if (s) begin
          m.phase = PH_HOLD; m.hold_left = p.rst_hold; m.done = 1'b0; m.tout = 1'b0;
          m.cycles = 0; m.retired = 0; m.run_len = 0; m.rearmed = 1'b0;
        end
      end
      PH_HOLD: begin
        m.hold_left--;
        if (m.hold_left == 0) m.phase = PH_RUN;
      end
      PH_RUN: begin
        m.cycles++;
        if (v) begin
          m.retired++;
          if (m.run_len > 0 && pcx == m.last_pc) m.run_len++;
          else begin
            m.run_len = 1;
            m.last_pc = pcx;
          end
          end_hit = (m.run_len == p.stall_limit);
        end
        to_hit = (m.cycles == p.timeout);
        re_hit = (p.rearm_at != 0) && !m.rearmed && (m.cycles == p.rearm_at);
        if (end_hit) begin
          m.phase = PH_DONE; m.done = 1'b1;
        end else if (to_hit) begin
          m.phase = PH_TOUT; m.tout = 1'b1;
        end else if (re_hit) begin
          m.phase = PH_REARM; m.rearmed = 1'b1; m.rearm_left = p.rearm_len;
          m.retired = 0; m.run_len = 0;
        end
      end
      PH_REARM: begin
        m.cycles++;
        m.retired = 0;
        m.run_len = 0;
        if (m.cycles == p.timeout) begin
          m.phase = PH_TOUT; m.tout = 1'b1;
        end else begin
          m.rearm_left--;
          if (m.rearm_left == 0) m.phase = PH_RUN;
        end
      end
      default: m.phase = PH_IDLE;
    endcase
    return m;
  endfunction

  function automatic exp_t expect_of(input mdl_t m);
    exp_t e;
    e.st  = 3'(m.phase);
    e.cr  = (m.phase != PH_RUN);
    e.rn  = (m.phase == PH_RUN);
    e.dn  = m.done;
    e.to  = m.tout;
    e.cyc = 32'(m.cycles);
    e.ret = 32'(m.retired);
    return e;
  endfunction

  function automatic exp_t act(input int i);
    exp_t a;
    case (i)
      0:       a = {st0, cr_o[0], rn_o[0], dn_o[0], to_o[0], cyc0, ret0};
      1:       a = {st1, cr_o[1], rn_o[1], dn_o[1], to_o[1], cyc1, ret1};
      default: a = {st2, cr_o[2], rn_o[2], dn_o[2], to_o[2], cyc2, ret2};
    endcase
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // One clock: drive inputs, advance the models on the edge, queue expectations.
  task automatic cyc(input logic r, input logic s, input logic v, input logic [31:0] p);
    trio_t t;
    reset = r; start = s; pc_valid = v; pc = p;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      m[i]   = step(m[i], pr[i], r, s, v, p);
      t.e[i] = expect_of(m[i]);
    end
    sbq.push_back(t);
    @(negedge clk);
  endtask

  // Monitor: compare each instance's registered outputs against the queue.
  initial begin
    trio_t t;
    exp_t  a;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        t = sbq.pop_front();
        for (int i = 0; i < 3; i++) begin
          a = act(i);
          checks++;
          if (a !== t.e[i]) begin
            errors++;
            $display("FAIL sb inst%0d @%0t: got st=%0d cr=%0b rn=%0b done=%0b tout=%0b cyc=%0d ret=%0d; expected st=%0d cr=%0b rn=%0b done=%0b tout=%0b cyc=%0d ret=%0d",
                     i, $time, a.st, a.cr, a.rn, a.dn, a.to, a.cyc, a.ret,
                     t.e[i].st, t.e[i].cr, t.e[i].rn, t.e[i].dn, t.e[i].to, t.e[i].cyc, t.e[i].ret);
          end
        end
      end
    end
  end

  // Driver: directed scenarios, then random traffic.
  initial begin
    int          hold_seen, rearm_seen, rearm_min, rearm_max;
    logic [31:0] prev_pc, p;
    logic        r, s, v;

    pr[0] = '{RH, SL, TO_0, 0,    RL};
    pr[1] = '{RH, SL, TO_1, 0,    RL};
    pr[2] = '{RH, SL, TO_2, RA_2, RL};
    for (int i = 0; i < 3; i++) m[i] = step(m[i], pr[i], 1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0; start = 1'b0; pc_valid = 1'b0; pc = 32'd0;
    @(negedge clk);

    // Power-on reset, then a start pulse and the HOLD window.
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("reset_state", {29'd0, st0}, 32'd0);
    chk("reset_cpu_reset", {31'd0, cr_o[0]}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    hold_seen = 0;
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    if (st0 == 3'd1 && cr_o[0]) hold_seen++;
    for (int j = 0; j < 4; j++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'd0);
      if (st0 == 3'd1 && cr_o[0]) hold_seen++;
    end
    chk("hold_cycles", 32'(hold_seen), 32'd4);
    chk("running_after_hold", {31'd0, rn_o[0]}, 32'd1);

    // Program end: three PCs, then seven more retires at the last one.
    cyc(1'b1, 1'b0, 1'b1, 32'h3000);
    cyc(1'b1, 1'b0, 1'b1, 32'h3004);
    for (int j = 0; j < 8; j++) cyc(1'b1, 1'b0, 1'b1, 32'h3008);
    chk("end_done", {31'd0, dn_o[0]}, 32'd1);
    chk("end_state", {29'd0, st0}, 32'd4);
    chk("end_retired", ret0, 32'd10);
    chk("end_cycles", cyc0, 32'd10);

    // Watchdog on u1/u2, single re-reset on u2, distinct PCs throughout.
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    for (int j = 0; j < 4; j++) cyc(1'b1, 1'b0, 1'b0, 32'd0);
    rearm_seen = 0; rearm_min = 32'h7fffffff; rearm_max = 0;
    for (int j = 1; j <= 140; j++) begin
      cyc(1'b1, 1'b0, 1'b1, 32'h4000 + 32'(4 * j));
      if (st2 == 3'd3 && cr_o[2] && !rn_o[2]) begin
        rearm_seen++;
        if (int'(cyc2) < rearm_min) rearm_min = int'(cyc2);
        if (int'(cyc2) > rearm_max) rearm_max = int'(cyc2);
      end
    end
    chk("tout_flag", {31'd0, to_o[1]}, 32'd1);
    chk("tout_state", {29'd0, st1}, 32'd5);
    chk("tout_cycles", cyc1, 32'd50);
    chk("tout_done", {31'd0, dn_o[1]}, 32'd0);
    chk("rearm_len", 32'(rearm_seen), 32'd15);
    chk("rearm_first", 32'(rearm_min), 32'd20);
    chk("rearm_last", 32'(rearm_max), 32'd34);
    chk("rearm_tout_cycles", cyc2, 32'd120);

    // Reset in the middle of u0's run, then stall limit landing on TIMEOUT-1.
    cyc(1'b0, 1'b0, 1'b1, 32'h1234);
    cyc(1'b0, 1'b0, 1'b1, 32'h1238);
    chk("midrun_reset_state", {29'd0, st0}, 32'd0);
    chk("midrun_reset_cycles", cyc0, 32'd0);
    chk("midrun_reset_running", {31'd0, rn_o[0]}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    for (int j = 0; j < 4; j++) cyc(1'b1, 1'b0, 1'b0, 32'd0);
    for (int j = 1; j <= 50; j++)
      cyc(1'b1, 1'b0, 1'b1, (j <= 42) ? (32'h5000 + 32'(4 * j)) : 32'h6000);
    chk("tie_done", {31'd0, dn_o[1]}, 32'd1);
    chk("tie_timeout", {31'd0, to_o[1]}, 32'd0);
    chk("tie_cycles", cyc1, 32'd50);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);

    // Random traffic with a bias towards repeating the previous PC.
    prev_pc = 32'h100;
    for (int j = 0; j < 3000; j++) begin
      r = ($urandom_range(0, 199) != 0);
      s = ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) p = prev_pc;
      else p = 32'h100 + 32'(4 * $urandom_range(0, 2));
      prev_pc = p;
      cyc(r, s, v, p);
    end
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
